// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer driving an external 1-bit full adder, one bit pair per clock.
// Optional signed-overflow output is enabled with `define SERIAL_ADD_OVF_EN.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_areg;
    logic [WIDTH-1:0] r_breg;
    logic             r_creg;
    // Only the upper WIDTH-1 result bits need storing; the newest bit arrives on fa_s.
    logic [WIDTH-2:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] w_acc_full;

    assign w_acc_full = {fa_s, r_acc};

    assign fa_a  = r_areg[0];
    assign fa_b  = r_breg[0];
    assign fa_ci = r_creg;
    assign busy  = r_busy;
    assign done  = r_done;
    assign sum   = r_sum;
    assign cout  = r_cout;

    // Sequencer: operand load, per-bit shift, result capture and handshake flags.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_areg  <= {WIDTH{1'b0}};
            r_breg  <= {WIDTH{1'b0}};
            r_creg  <= 1'b0;
            r_acc   <= {(WIDTH-1){1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_sum   <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_areg  <= a;
                        r_breg  <= b;
                        r_creg  <= cin;
                        r_cnt   <= {CW{1'b0}};
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_acc  <= (WIDTH-1)'(w_acc_full >> 1);
                    r_creg <= fa_co;
                    r_areg <= r_areg >> 1;
                    r_breg <= r_breg >> 1;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_sum   <= w_acc_full;
                        r_cout  <= fa_co;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_done  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;

    // Signed overflow is the carry into the MSB xor the carry out of it.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_RUN && r_cnt == LAST) begin
            r_ovf <= r_creg ^ fa_co;
        end else begin
            r_ovf <= r_ovf;
        end
    end
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq with a behavioural full adder closing the loop.
module tb_serial_add_seq;

    logic       hz100 = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       fa_a, fa_b, fa_ci, fa_s, fa_co;
    logic       busy, done, cout;
    logic [7:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t tbl[9];

    serial_add_seq #(.WIDTH(8)) dut (
        .hz100(hz100), .reset(reset), .start(start),
        .a(a), .b(b), .cin(cin),
        .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci),
        .fa_s(fa_s), .fa_co(fa_co),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 hz100 = ~hz100;

    assign fa_s  = fa_a ^ fa_b ^ fa_ci;
    assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Pulse start, wait for done (bounded), check latency and the one-cycle done pulse.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        int edges;
        @(negedge hz100);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(negedge hz100);
        start = 1'b0;
        a = 8'hA5; b = 8'h5A; cin = ~vc;
        chk("busy_rise", {31'd0, busy}, 32'd1);
        edges = 1;
        while (done !== 1'b1 && edges < 40) begin
            @(negedge hz100);
            edges++;
        end
        chk("latency", edges, 32'd9);
        @(negedge hz100);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_drop", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int dones;
        int gap;
        logic [8:0] exp9;
        logic [7:0] ra, rb;
        logic       rc;

        tbl[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        tbl[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[8] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

        reset = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_fa", {29'd0, fa_a, fa_b, fa_ci}, 32'd0);
        @(negedge hz100);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin);
            chk($sformatf("tbl%0d_sum", i), {24'd0, sum}, {24'd0, tbl[i].s});
            chk($sformatf("tbl%0d_cout", i), {31'd0, cout}, {31'd0, tbl[i].co});
`ifdef SERIAL_ADD_OVF_EN
            chk($sformatf("tbl%0d_ovf", i), {31'd0, ovf}, {31'd0, tbl[i].ov});
`endif
        end

        // Start pulsed mid-RUN must be ignored.
        @(negedge hz100);
        a = 8'h10; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge hz100);
        start = 1'b0;
        repeat (3) @(negedge hz100);
        a = 8'hFF; start = 1'b1;
        @(negedge hz100);
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge hz100);
            if (done === 1'b1) dones++;
        end
        chk("ignore_done_count", dones, 32'd1);
        chk("ignore_sum", {24'd0, sum}, 32'h11);
        chk("ignore_cout", {31'd0, cout}, 32'd0);

        // Asynchronous reset after edge 4 of RUN.
        @(negedge hz100);
        a = 8'hC3; b = 8'h3C; cin = 1'b1; start = 1'b1;
        @(negedge hz100);
        start = 1'b0;
        repeat (4) @(negedge hz100);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_sum", {24'd0, sum}, 32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        chk("abort_fa", {29'd0, fa_a, fa_b, fa_ci}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(negedge hz100);
        reset = 1'b1;
        run_op(8'h7F, 8'h01, 1'b0);
        chk("post_rst_sum", {24'd0, sum}, 32'h80);
        chk("post_rst_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("post_rst_ovf", {31'd0, ovf}, 32'd1);
`endif

        // Back-to-back random adds with start held high.
        @(negedge hz100);
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
        a = ra; b = rb; cin = rc; start = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            gap = 0;
            do begin
                @(negedge hz100);
                gap++;
            end while (done !== 1'b1 && gap < 40);
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            chk("rand_result", {23'd0, cout, sum}, {23'd0, exp9});
            chk("rand_spacing", gap, (n == 0) ? 32'd9 : 32'd10);
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            a = ra; b = rb; cin = rc;
        end
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
